sprite_frame_sequencer: RTL and testbench

Controls the sprite drawing datapath for both players. It holds per-player shadow copies of action state and x-position, and updates them only at the start of vertical blanking, so the renderers never tear mid-frame. It owns the per-player action timers that select animation frames, advancing them at a configurable animation rate. It reports one-shot action completion back to the game logic. It sits between the game-logic FSM and the sprite drawing block, driving its state, position and action-timer inputs.

---
 rtl/sprite_frame_sequencer_pkg.sv | 48 ++++
 rtl/sprite_frame_sequencer_anim_player_ctrl.sv | 98 +++++++++
 rtl/sprite_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_sprite_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_frame_sequencer_pkg.sv
// Shared constants for the sprite frame sequencer: state codes, animation
// lengths and the sequencer FSM encoding. The action lengths here must agree
// with the frame thresholds used by the sprite offset generator.
package sprite_frame_sequencer_pkg;

   localparam int STATE_DEPTH        = 3;
   localparam int SPRITE_INDEX_DEPTH = 3;
   localparam int POS_W              = 10;

   localparam logic [STATE_DEPTH-1:0] NOTHING       = 3'd0;
   localparam logic [STATE_DEPTH-1:0] WALK_FORWARD  = 3'd1;
   localparam logic [STATE_DEPTH-1:0] WALK_BACKWARD = 3'd2;
   localparam logic [STATE_DEPTH-1:0] GRAB          = 3'd3;
   localparam logic [STATE_DEPTH-1:0] KICK          = 3'd4;
   localparam logic [STATE_DEPTH-1:0] WIN           = 3'd5;
   localparam logic [STATE_DEPTH-1:0] LOSE          = 3'd6;

   localparam int GRAB_LEN       = 4;
   localparam int KICK_LEN       = 6;
   localparam int WALK_CYCLE_LEN = 6;

   localparam logic [SPRITE_INDEX_DEPTH-1:0] WALK_LAST =
      SPRITE_INDEX_DEPTH'(WALK_CYCLE_LEN - 1);

   typedef enum logic [1:0] {
      S_ACTIVE  = 2'd0,
      S_LATCH   = 2'd1,
      S_ADVANCE = 2'd2
   } seq_state_e;

   // True for the one-shot actions that lock the state until they finish.
   function automatic logic is_action(input logic [STATE_DEPTH-1:0] st);
      return (st == GRAB) || (st == KICK);
   endfunction

   // Final animation index of a one-shot action; zero for everything else.
   function automatic logic [SPRITE_INDEX_DEPTH-1:0] action_last(
      input logic [STATE_DEPTH-1:0] st);
      logic [SPRITE_INDEX_DEPTH-1:0] r;
      case (st)
         GRAB:    r = SPRITE_INDEX_DEPTH'(GRAB_LEN - 1);
         KICK:    r = SPRITE_INDEX_DEPTH'(KICK_LEN - 1);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sprite_frame_sequencer_anim_player_ctrl.sv
// One player's frame-stable shadow registers: state, x-position, animation
// timer and the one-shot action completion pulse. The latch strobe samples the
// game-logic request; the advance strobe steps the animation timer.
module anim_player_ctrl
   import sprite_frame_sequencer_pkg::*;
#(
   parameter int START_X = 100
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          latch_i,
   input  logic                          advance_i,
   input  logic                          tick_i,
   input  logic [STATE_DEPTH-1:0]        req_state_i,
   input  logic [POS_W-1:0]              req_pos_i,
   output logic [STATE_DEPTH-1:0]        state_o,
   output logic [POS_W-1:0]              pos_o,
   output logic [SPRITE_INDEX_DEPTH-1:0] timer_o,
   output logic                          done_o
);

   logic [STATE_DEPTH-1:0]        state_q, state_d;
   logic [POS_W-1:0]              pos_q, pos_d;
   logic [SPRITE_INDEX_DEPTH-1:0] timer_q, timer_d;
   logic                          changed_q, changed_d;
   logic                          done_q, done_d;

   logic [SPRITE_INDEX_DEPTH-1:0] last;
   logic [SPRITE_INDEX_DEPTH-1:0] timer_inc;
   logic                          locked;
   logic                          preempt;

   assign last      = action_last(state_q);
   assign timer_inc = timer_q + 1'b1;
   assign locked    = is_action(state_q) && (timer_q < last);
   assign preempt   = (req_state_i == WIN) || (req_state_i == LOSE);

   // Next-state: request sampling on latch, animation step on advance.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      timer_d   = timer_q;
      changed_d = changed_q;
      done_d    = 1'b0;

      if (latch_i) begin
         pos_d     = req_pos_i;
         changed_d = 1'b0;
         if ((!locked || preempt) && (req_state_i != state_q)) begin
            state_d   = req_state_i;
            timer_d   = '0;
            changed_d = 1'b1;
         end
      end

      // A state change in this frame wins over the tick: timer stays at 0.
      if (advance_i && tick_i && !changed_q) begin
         case (state_q)
            WALK_FORWARD, WALK_BACKWARD: begin
               timer_d = (timer_q == WALK_LAST) ? '0 : timer_inc;
            end
            GRAB, KICK: begin
               if (timer_q < last) begin
                  timer_d = timer_inc;
                  done_d  = (timer_inc == last);
               end
            end
            WIN: begin
               if (timer_q != '1) timer_d = timer_inc;
            end
            default: timer_d = '0;
         endcase
      end
   end

   // Shadow registers; reset restores the power-on pose.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= NOTHING;
         pos_q     <= POS_W'(START_X);
         timer_q   <= '0;
         changed_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         timer_q   <= timer_d;
         changed_q <= changed_d;
         done_q    <= done_d;
      end
   end

   assign state_o = state_q;
   assign pos_o   = pos_q;
   assign timer_o = timer_q;
   assign done_o  = done_q;

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Frame sequencer for both players' sprites. Detects the start of vertical
// blanking once per frame, then latches requests and advances the animation
// timers so the renderers only ever see values that change between frames.
// Each update is written on the clock edge that enters the named FSM state,
// so latched values are visible while in S_LATCH and advanced timers while in
// S_ADVANCE.
module sprite_frame_sequencer
   import sprite_frame_sequencer_pkg::*;
#(
   parameter int FRAME_DIV   = 2,
   parameter int VBLANK_LINE = 480,
   parameter int P1_START_X  = 100,
   parameter int P2_START_X  = 480
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9:0]                    vcount,
   input  logic [STATE_DEPTH-1:0]        req_state_p1,
   input  logic [STATE_DEPTH-1:0]        req_state_p2,
   input  logic [9:0]                    req_pos_p1,
   input  logic [9:0]                    req_pos_p2,
   output logic [STATE_DEPTH-1:0]        state_p1,
   output logic [STATE_DEPTH-1:0]        state_p2,
   output logic [9:0]                    sprite_position_p1,
   output logic [9:0]                    sprite_position_p2,
   output logic [SPRITE_INDEX_DEPTH-1:0] action_timer_p1,
   output logic [SPRITE_INDEX_DEPTH-1:0] action_timer_p2,
   output logic                          action_done_p1,
   output logic                          action_done_p2,
   output logic                          anim_tick
);

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   seq_state_e        fsm_q, fsm_d;
   logic              vb_q, vb_prev_q;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick_pend_q, tick_pend_d;
   logic              anim_tick_q, anim_tick_d;
   logic              trigger;
   logic              latch_en;
   logic              advance_en;

   assign trigger = vb_q && !vb_prev_q;

   // Registered blanking flag and its delayed copy; both reset high so a
   // release inside blanking does not fire a trigger.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vb_q      <= 1'b1;
         vb_prev_q <= 1'b1;
      end else begin
         vb_q      <= (vcount >= 10'(VBLANK_LINE));
         vb_prev_q <= vb_q;
      end
   end

   // Sequencer next-state and update strobes; late triggers are ignored.
   always_comb begin
      fsm_d      = fsm_q;
      latch_en   = 1'b0;
      advance_en = 1'b0;
      case (fsm_q)
         S_ACTIVE: begin
            if (trigger) begin
               fsm_d    = S_LATCH;
               latch_en = 1'b1;
            end
         end
         S_LATCH: begin
            fsm_d      = S_ADVANCE;
            advance_en = 1'b1;
         end
         S_ADVANCE: fsm_d = S_ACTIVE;
         default:   fsm_d = S_ACTIVE;
      endcase
   end

   // Frame divider: one animation tick every FRAME_DIV frames.
   always_comb begin
      div_d       = div_q;
      tick_pend_d = tick_pend_q;
      if (latch_en) begin
         if (div_q == DIV_LAST) begin
            div_d       = '0;
            tick_pend_d = 1'b1;
         end else begin
            div_d       = div_q + 1'b1;
            tick_pend_d = 1'b0;
         end
      end
      anim_tick_d = advance_en && tick_pend_q;
   end

   // Sequencer state, divider and tick pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q       <= S_ACTIVE;
         div_q       <= '0;
         tick_pend_q <= 1'b0;
         anim_tick_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         div_q       <= div_d;
         tick_pend_q <= tick_pend_d;
         anim_tick_q <= anim_tick_d;
      end
   end

   assign anim_tick = anim_tick_q;

   anim_player_ctrl #(.START_X(P1_START_X)) u_p1 (
      .clk         (clk),
      .reset       (reset),
      .latch_i     (latch_en),
      .advance_i   (advance_en),
      .tick_i      (tick_pend_q),
      .req_state_i (req_state_p1),
      .req_pos_i   (req_pos_p1),
      .state_o     (state_p1),
      .pos_o       (sprite_position_p1),
      .timer_o     (action_timer_p1),
      .done_o      (action_done_p1)
   );

   anim_player_ctrl #(.START_X(P2_START_X)) u_p2 (
      .clk         (clk),
      .reset       (reset),
      .latch_i     (latch_en),
      .advance_i   (advance_en),
      .tick_i      (tick_pend_q),
      .req_state_i (req_state_p2),
      .req_pos_i   (req_pos_p2),
      .state_o     (state_p2),
      .pos_o       (sprite_position_p2),
      .timer_o     (action_timer_p2),
      .done_o      (action_done_p2)
   );

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Randomized bench for sprite_frame_sequencer with a frame-level reference
// model of the per-player state, position and animation timer rules.
module tb_sprite_frame_sequencer;
   import sprite_frame_sequencer_pkg::*;

   localparam int FRAME_DIV   = 2;
   localparam int VBLANK_LINE = 480;
   localparam int P1_START_X  = 100;
   localparam int P2_START_X  = 480;
   localparam int TMAX        = (1 << SPRITE_INDEX_DEPTH) - 1;

   logic                          clk = 1'b0;
   logic                          reset = 1'b0;
   logic [9:0]                    vcount = 10'd500;
   logic [STATE_DEPTH-1:0]        req_state_p1 = '0, req_state_p2 = '0;
   logic [9:0]                    req_pos_p1 = '0, req_pos_p2 = '0;
   logic [STATE_DEPTH-1:0]        state_p1, state_p2;
   logic [9:0]                    sprite_position_p1, sprite_position_p2;
   logic [SPRITE_INDEX_DEPTH-1:0] action_timer_p1, action_timer_p2;
   logic                          action_done_p1, action_done_p2, anim_tick;

   int errors = 0;
   int checks = 0;

   // reference model
   int m_state[2];
   int m_pos[2];
   int m_timer[2];
   bit m_chg[2];
   bit m_tick;
   int m_frames;
   bit e_done[2];
   bit e_anim;
   int done_seen;

   always #5 clk = ~clk;

   sprite_frame_sequencer #(
      .FRAME_DIV(FRAME_DIV), .VBLANK_LINE(VBLANK_LINE),
      .P1_START_X(P1_START_X), .P2_START_X(P2_START_X)
   ) dut (
      .clk(clk), .reset(reset), .vcount(vcount),
      .req_state_p1(req_state_p1), .req_state_p2(req_state_p2),
      .req_pos_p1(req_pos_p1), .req_pos_p2(req_pos_p2),
      .state_p1(state_p1), .state_p2(state_p2),
      .sprite_position_p1(sprite_position_p1), .sprite_position_p2(sprite_position_p2),
      .action_timer_p1(action_timer_p1), .action_timer_p2(action_timer_p2),
      .action_done_p1(action_done_p1), .action_done_p2(action_done_p2),
      .anim_tick(anim_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int act_len(input int s);
      if (s == int'(GRAB)) return GRAB_LEN;
      if (s == int'(KICK)) return KICK_LEN;
      return 0;
   endfunction

   task automatic model_reset();
      m_state = '{int'(NOTHING), int'(NOTHING)};
      m_pos   = '{P1_START_X, P2_START_X};
      m_timer = '{0, 0};
      m_chg   = '{0, 0};
      m_frames = 0;
      e_done  = '{0, 0};
      e_anim  = 0;
   endtask

   // Start of blanking: sample requests, decide whether this frame ticks.
   task automatic model_latch(input int rs[2], input int rp[2]);
      m_tick = ((m_frames % FRAME_DIV) == FRAME_DIV - 1);
      m_frames++;
      for (int p = 0; p < 2; p++) begin
         bit locked;
         bit accept;
         locked = (act_len(m_state[p]) != 0) && (m_timer[p] < act_len(m_state[p]) - 1);
         accept = !locked || rs[p] == int'(WIN) || rs[p] == int'(LOSE);
         m_pos[p] = rp[p];
         m_chg[p] = 0;
         if (accept && rs[p] != m_state[p]) begin
            m_state[p] = rs[p];
            m_timer[p] = 0;
            m_chg[p]   = 1;
         end
      end
   endtask

   task automatic model_advance();
      e_anim = m_tick;
      for (int p = 0; p < 2; p++) begin
         e_done[p] = 0;
         if (m_tick && !m_chg[p]) begin
            if (m_state[p] == int'(WALK_FORWARD) || m_state[p] == int'(WALK_BACKWARD))
               m_timer[p] = (m_timer[p] + 1) % WALK_CYCLE_LEN;
            else if (act_len(m_state[p]) != 0) begin
               if (m_timer[p] < act_len(m_state[p]) - 1) begin
                  m_timer[p]++;
                  e_done[p] = (m_timer[p] == act_len(m_state[p]) - 1);
               end
            end else if (m_state[p] == int'(WIN))
               m_timer[p] = (m_timer[p] < TMAX) ? m_timer[p] + 1 : TMAX;
            else
               m_timer[p] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".st1"}, state_p1, m_state[0]);
      chk({tag, ".st2"}, state_p2, m_state[1]);
      chk({tag, ".pos1"}, sprite_position_p1, m_pos[0]);
      chk({tag, ".pos2"}, sprite_position_p2, m_pos[1]);
      chk({tag, ".tm1"}, action_timer_p1, m_timer[0]);
      chk({tag, ".tm2"}, action_timer_p2, m_timer[1]);
      chk({tag, ".dn1"}, action_done_p1, e_done[0]);
      chk({tag, ".dn2"}, action_done_p2, e_done[1]);
      chk({tag, ".tick"}, anim_tick, e_anim);
   endtask

   // One video frame: active lines with request churn, then blanking.
   task automatic run_frame(input int s1, input int p1, input int s2, input int p2);
      int rs[2];
      int rp[2];
      e_done = '{0, 0};
      e_anim = 0;
      vcount = 10'($urandom_range(0, VBLANK_LINE - 1));
      req_state_p1 = STATE_DEPTH'($urandom_range(0, 7));
      req_pos_p1   = 10'($urandom_range(0, 639));
      step();
      check_all("act0");
      rs = '{s1, s2};
      rp = '{p1, p2};
      req_state_p1 = STATE_DEPTH'(s1);
      req_state_p2 = STATE_DEPTH'(s2);
      req_pos_p1   = 10'(p1);
      req_pos_p2   = 10'(p2);
      for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++) begin
         vcount = 10'($urandom_range(0, VBLANK_LINE - 1));
         step();
         check_all("act");
      end
      vcount = 10'(VBLANK_LINE + $urandom_range(0, 40));
      step();
      check_all("e1");
      model_latch(rs, rp);
      step();
      check_all("e2");
      model_advance();
      step();
      if (action_done_p1 === 1'b1) done_seen++;
      check_all("e3");
      e_done = '{0, 0};
      e_anim = 0;
      step();
      check_all("e4");
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
         vcount = vcount + 10'd1;
         step();
         check_all("vbhold");
      end
   endtask

   initial begin
      model_reset();
      done_seen = 0;

      // reset held, then released inside blanking: nothing may fire
      req_state_p1 = KICK;
      req_pos_p1   = 10'd321;
      step();
      check_all("rst");
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_all("post_rst");
      end

      // walk cycle with request held
      for (int f = 0; f < 2 * WALK_CYCLE_LEN + 2; f++)
         run_frame(int'(WALK_FORWARD), 200 + 100 * (f % 2), int'(NOTHING), 480);

      // kick, then NOTHING requested while locked
      done_seen = 0;
      run_frame(int'(KICK), 150, int'(NOTHING), 480);
      for (int f = 0; f < 2 * KICK_LEN + 2; f++)
         run_frame(int'(NOTHING), 150, int'(NOTHING), 480);
      chk("kick_done_once", done_seen, 1);
      chk("kick_released", state_p1, NOTHING);

      // grab preempted by LOSE
      run_frame(int'(GRAB), 160, int'(NOTHING), 480);
      for (int f = 0; f < 6 && m_timer[0] != 1; f++)
         run_frame(int'(GRAB), 160, int'(NOTHING), 480);
      chk("grab_timer1", action_timer_p1, 1);
      done_seen = 0;
      run_frame(int'(LOSE), 160, int'(NOTHING), 480);
      chk("lose_preempt", state_p1, LOSE);
      chk("lose_timer", action_timer_p1, 0);
      chk("lose_nodone", done_seen, 0);

      // both players change state on a tick frame
      for (int f = 0; f < FRAME_DIV && (m_frames % FRAME_DIV) != FRAME_DIV - 1; f++)
         run_frame(int'(LOSE), 160, int'(NOTHING), 480);
      run_frame(int'(WALK_BACKWARD), 170, int'(KICK), 470);
      chk("both_t1", action_timer_p1, 0);
      chk("both_t2", action_timer_p2, 0);

      // WIN saturates
      for (int f = 0; f < 2 * TMAX + 4; f++)
         run_frame(int'(WIN), 300, int'(WIN), 310);
      chk("win_sat", action_timer_p1, TMAX);

      // reset in the middle of an update
      req_state_p1 = WALK_FORWARD;
      req_pos_p1   = 10'd55;
      vcount = 10'd100;
      step();
      vcount = 10'd490;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      vcount = 10'd500;
      step();
      check_all("mid_rst_hold");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("mid_rst_rel");
      end

      // randomized traffic
      for (int f = 0; f < 60; f++)
         run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 639)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 639)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
